// File: rtl/cpu_trace_buffer.sv
// cpu_trace_buffer: circular trace capture of the CPU debug outputs with a PC-match
// trigger and post-trigger sample count, drained oldest-first over a valid/ready port.
// Optional feature: define TRACE_DEDUP_EN to drop samples whose pc repeats the last
// written pc (suppresses stall and reset-hold cycles).
module cpu_trace_buffer #(
   parameter int unsigned DEPTH = 16,
   localparam int unsigned AW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [31:0]   debug_pc,
   input  logic [31:0]   debug_instruction,
   input  logic [31:0]   debug_alu_result,
   input  logic          arm,
   input  logic [31:0]   trig_pc,
   input  logic [AW-1:0] post_cnt,
   output logic          rd_valid,
   output logic [95:0]   rd_data,
   input  logic          rd_ready,
   output logic [1:0]    state,
   output logic [AW:0]   count,
   output logic          overflow
);

   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StArmed = 2'b01,
      StPost  = 2'b10,
      StDone  = 2'b11
   } state_e;

   localparam logic [AW:0]   Full   = (AW + 1)'(DEPTH);
   localparam logic [AW-1:0] OneRem = {{(AW - 1){1'b0}}, 1'b1};

   state_e        st;
   logic [AW:0]   cnt;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] remaining;
   logic [AW-1:0] post_q;
   logic [31:0]   trig_q;
   logic          ovf;
   logic          capturing;
   logic          dup;
   logic          wr_en;
   logic          rd_fire;
   logic [95:0]   mem [DEPTH];

   assign capturing = (st == StArmed) || (st == StPost);
   // arm takes priority over both capture and readout
   assign wr_en     = !arm && capturing && !dup;
   assign rd_valid  = (st == StDone) && (cnt != '0);
   assign rd_fire   = !arm && rd_valid && rd_ready;
   // when full (cnt == DEPTH) the low bits are 0, so rd_ptr == wr_ptr: the oldest entry
   assign rd_ptr    = wr_ptr - cnt[AW-1:0];
   assign rd_data   = rd_valid ? mem[rd_ptr] : '0;
   assign state     = st;
   assign count     = cnt;
   assign overflow  = ovf;

`ifdef TRACE_DEDUP_EN
   logic [31:0] last_pc;
   logic        last_vld;

   assign dup = last_vld && (debug_pc == last_pc);

   // Track pc of the most recent written sample; cleared on arm so the first is always kept
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_pc  <= '0;
         last_vld <= 1'b0;
      end else if (arm) begin
         last_vld <= 1'b0;
      end else if (wr_en) begin
         last_pc  <= debug_pc;
         last_vld <= 1'b1;
      end
   end
`else
   assign dup = 1'b0;
`endif

   // Trace RAM, not reset
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= {debug_pc, debug_instruction, debug_alu_result};
      end
   end

   // Capture/readout FSM with pointer, occupancy and overflow bookkeeping
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st        <= StIdle;
         cnt       <= '0;
         wr_ptr    <= '0;
         ovf       <= 1'b0;
         trig_q    <= '0;
         post_q    <= '0;
         remaining <= '0;
      end else if (arm) begin
         st     <= StArmed;
         cnt    <= '0;
         wr_ptr <= '0;
         ovf    <= 1'b0;
         trig_q <= trig_pc;
         post_q <= post_cnt;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (cnt == Full) begin
               ovf <= 1'b1;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
         unique case (st)
            StIdle: ;
            StArmed: begin
               if (wr_en && (debug_pc == trig_q)) begin
                  if (post_q == '0) begin
                     st <= StDone;
                  end else begin
                     remaining <= post_q;
                     st        <= StPost;
                  end
               end
            end
            StPost: begin
               if (wr_en) begin
                  remaining <= remaining - 1'b1;
                  if (remaining == OneRem) begin
                     st <= StDone;
                  end
               end
            end
            StDone: begin
               if (rd_fire) begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: st <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed self-checking bench for cpu_trace_buffer (DEPTH=8).
module tb_cpu_trace_buffer;

   localparam int unsigned DEPTH = 8;
   localparam int unsigned AW    = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [31:0]   debug_pc = '0;
   logic [31:0]   debug_instruction = '0;
   logic [31:0]   debug_alu_result = '0;
   logic          arm = 1'b0;
   logic [31:0]   trig_pc = '0;
   logic [AW-1:0] post_cnt = '0;
   logic          rd_valid;
   logic [95:0]   rd_data;
   logic          rd_ready = 1'b0;
   logic [1:0]    state;
   logic [AW:0]   count;
   logic          overflow;

   int checks = 0;
   int errors = 0;
   int n;

   cpu_trace_buffer #(.DEPTH(DEPTH)) dut (
      .clk               (clk),
      .rst               (rst),
      .debug_pc          (debug_pc),
      .debug_instruction (debug_instruction),
      .debug_alu_result  (debug_alu_result),
      .arm               (arm),
      .trig_pc           (trig_pc),
      .post_cnt          (post_cnt),
      .rd_valid          (rd_valid),
      .rd_data           (rd_data),
      .rd_ready          (rd_ready),
      .state             (state),
      .count             (count),
      .overflow          (overflow)
   );

   always #5 clk = ~clk;

   function automatic logic [95:0] exp_word(input logic [31:0] pc);
      return {pc, pc ^ 32'h1357_9BDF, pc + 32'h100};
   endfunction

   task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_dbg(input logic [31:0] pc);
      debug_pc          = pc;
      debug_instruction = pc ^ 32'h1357_9BDF;
      debug_alu_result  = pc + 32'h100;
   endtask

   // Arm cycle presents the trigger pc itself; it must not be written
   task automatic do_arm(input logic [31:0] trig, input logic [AW-1:0] post);
      arm      = 1'b1;
      trig_pc  = trig;
      post_cnt = post;
      set_dbg(trig);
      cyc();
      arm = 1'b0;
   endtask

   task automatic stream(input logic [1:0] until_st, output int nw);
      logic [31:0] pc;
      pc = '0;
      nw = 0;
      for (int i = 0; i < 64; i++) begin
         set_dbg(pc);
         cyc();
         nw++;
         if (state == until_st) break;
         pc += 32'd4;
      end
      check("stream_state", 96'(state), 96'(until_st));
   endtask

   task automatic drain(input logic [31:0] first_pc, input int num);
      for (int i = 0; i < num; i++) begin
         check("rd_valid", 96'(rd_valid), 96'(1));
         check("rd_count", 96'(count), 96'(num - i));
         check("rd_data", rd_data, exp_word(first_pc + 32'(4 * i)));
         rd_ready = 1'b1;
         cyc();
         rd_ready = 1'b0;
      end
      check("drain_valid_low", 96'(rd_valid), 96'(0));
      check("drain_data_zero", rd_data, 96'(0));
      check("drain_count_zero", 96'(count), 96'(0));
      check("drain_state_done", 96'(state), 96'(3));
   endtask

   initial begin
      // Reset values
      #2 rst = 1'b1;
      #1;
      check("rst_state", 96'(state), 96'(0));
      check("rst_count", 96'(count), 96'(0));
      check("rst_overflow", 96'(overflow), 96'(0));
      check("rst_rd_valid", 96'(rd_valid), 96'(0));
      check("rst_rd_data", rd_data, 96'(0));
      cyc();
      cyc();
      rst = 1'b0;

      // IDLE does not capture
      for (int i = 0; i < 3; i++) begin
         set_dbg(32'(i * 4));
         cyc();
      end
      check("idle_state", 96'(state), 96'(0));
      check("idle_count", 96'(count), 96'(0));

      // 1: trigger 0x10, two post samples
      do_arm(32'h10, 3'd2);
      check("arm_state", 96'(state), 96'(1));
      check("arm_count", 96'(count), 96'(0));
      stream(2'b11, n);
      check("t1_samples", 96'(n), 96'(7));
      check("t1_count", 96'(count), 96'(7));
      check("t1_overflow", 96'(overflow), 96'(0));
      drain(32'h00, 7);

      // 2: trigger late, history wraps
      do_arm(32'h40, 3'd2);
      stream(2'b11, n);
      check("t2_samples", 96'(n), 96'(19));
      check("t2_count", 96'(count), 96'(8));
      check("t2_overflow", 96'(overflow), 96'(1));
      drain(32'h2C, 8);

      // 3: post_cnt=0, DONE on the trigger sample; arm during readout wins over a read
      do_arm(32'h08, 3'd0);
      stream(2'b11, n);
      check("t3_samples", 96'(n), 96'(3));
      check("t3_count", 96'(count), 96'(3));
      rd_ready = 1'b1;
      do_arm(32'h08, 3'd0);
      rd_ready = 1'b0;
      check("arm_vs_read_state", 96'(state), 96'(1));
      check("arm_vs_read_count", 96'(count), 96'(0));
      check("arm_vs_read_valid", 96'(rd_valid), 96'(0));
      stream(2'b11, n);
      check("t3b_samples", 96'(n), 96'(3));
      drain(32'h00, 3);

      // 4: back-pressure holds output stable
      do_arm(32'h10, 3'd2);
      stream(2'b11, n);
      for (int i = 0; i < 3; i++) begin
         cyc();
         check("hold_valid", 96'(rd_valid), 96'(1));
         check("hold_data", rd_data, exp_word(32'h00));
         check("hold_count", 96'(count), 96'(7));
      end
      drain(32'h00, 7);

      // 5: async reset mid-POST, then re-run test 1
      do_arm(32'h40, 3'd4);
      stream(2'b10, n);
      check("t5_post_samples", 96'(n), 96'(17));
      #2 rst = 1'b1;
      #1;
      check("t5_rst_state", 96'(state), 96'(0));
      check("t5_rst_count", 96'(count), 96'(0));
      check("t5_rst_valid", 96'(rd_valid), 96'(0));
      check("t5_rst_overflow", 96'(overflow), 96'(1'b0));
      #1 rst = 1'b0;
      cyc();
      do_arm(32'h10, 3'd2);
      stream(2'b11, n);
      check("t5_rerun_samples", 96'(n), 96'(7));
      drain(32'h00, 7);

      // 6: repeated pc in ARMED
      do_arm(32'hFFFF_FF00, 3'd0);
      set_dbg(32'h00);
      cyc();
      set_dbg(32'h04);
      cyc();
      check("t6_count_pre", 96'(count), 96'(2));
      for (int i = 0; i < 5; i++) begin
         set_dbg(32'h08);
         cyc();
      end
`ifdef TRACE_DEDUP_EN
      check("t6_count_hold", 96'(count), 96'(3));
`else
      check("t6_count_hold", 96'(count), 96'(7));
`endif
      check("t6_state", 96'(state), 96'(1));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
